inst_mem_resp: RTL and testbench

INST_MEM_RESP -- requirements
Module: inst_mem_resp

---
 rtl/inst_mem_pkg.sv | 9 +
 rtl/resp_fifo2.sv | 32 +++
 rtl/inst_mem_resp.sv | 52 +++++
 tb/tb_inst_mem_resp.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/inst_mem_pkg.sv
// inst_mem_pkg: shared defaults and response entry type for the instruction memory
package inst_mem_pkg;
  localparam int ADDR_W = 10;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } resp_t;
endpackage

// File: rtl/resp_fifo2.sv
// resp_fifo2: 2-entry in-order response buffer with occupancy count
module resp_fifo2 import inst_mem_pkg::*; #(
  parameter logic [31:0] RST_INST = NOP_WORD
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  resp_t      din,
  input  logic       pop,
  output resp_t      dout,
  output logic [1:0] count
);
  resp_t q [2];
  logic  rp, wp;
  assign dout = q[rp];
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q[0]  <= resp_t'{inst: RST_INST, err: 1'b0};
      q[1]  <= resp_t'{inst: RST_INST, err: 1'b0};
      rp    <= 1'b0;
      wp    <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        q[wp] <= din;
        wp    <= !wp;
      end
      if (pop) rp <= !rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/inst_mem_resp.sv
// inst_mem_resp: loadable instruction memory with one-cycle fetch and a 2-deep response buffer
module inst_mem_resp #(
  parameter int          ADDR_W   = inst_mem_pkg::ADDR_W,
  parameter logic [31:0] NOP_WORD = inst_mem_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid_i,
  input  logic [31:0] req_addr_i,
  output logic        req_ready_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_inst_o,
  output logic        resp_err_o,
  input  logic        resp_ready_i,
  input  logic        wr_en_i,
  input  logic [31:0] wr_addr_i,
  input  logic [31:0] wr_data_i
);
  import inst_mem_pkg::resp_t;
  logic [31:0] mem [2**ADDR_W];
  resp_t       rd, head;
  logic        infl, pop, acc, req_err, wr_ok;
  logic [1:0]  cnt, occ;
  assign req_err = (|req_addr_i[1:0]) || (|req_addr_i[31:ADDR_W+2]);
  assign wr_ok = wr_en_i && !(|wr_addr_i[1:0]) && !(|wr_addr_i[31:ADDR_W+2]);
  assign pop = resp_valid_o && resp_ready_i;
  // a same-cycle pop frees a slot so a full pipe keeps streaming
  assign occ = cnt + {1'b0, infl} - {1'b0, pop};
  assign req_ready_o = rstn && !wr_en_i && (occ < 2'd2);
  assign acc = req_valid_i && req_ready_o;
  assign resp_valid_o = cnt != 2'd0;
  assign resp_inst_o = head.inst;
  assign resp_err_o = head.err;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) infl <= 1'b0;
    else infl <= acc;
  end
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr_i[ADDR_W+1:2]] <= wr_data_i;
    if (acc) rd <= req_err ? resp_t'{inst: NOP_WORD, err: 1'b1}
                           : resp_t'{inst: mem[req_addr_i[ADDR_W+1:2]], err: 1'b0};
  end
  resp_fifo2 #(.RST_INST(NOP_WORD)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (infl),
    .din   (rd),
    .pop   (pop),
    .dout  (head),
    .count (cnt)
  );
endmodule

// File: tb/tb_inst_mem_resp.sv
// tb_inst_mem_resp: directed and random fetch/load checks against a queue-based model
module tb_inst_mem_resp;
  logic        clk = 1'b0, rstn = 1'b0;
  logic        req_valid_i = 1'b0, resp_ready_i = 1'b0, wr_en_i = 1'b0;
  logic [31:0] req_addr_i = '0, wr_addr_i = '0, wr_data_i = '0;
  logic        req_ready_o, resp_valid_o, resp_err_o;
  logic [31:0] resp_inst_o;
  int n_chk = 0, n_err = 0, cyc = 0;
  typedef struct { logic [31:0] inst; bit err; int vis; } ent_t;
  ent_t q[$];
  logic [31:0] mdl [1024];

  inst_mem_resp dut (
    .clk(clk), .rstn(rstn), .req_valid_i(req_valid_i), .req_addr_i(req_addr_i),
    .req_ready_o(req_ready_o), .resp_valid_o(resp_valid_o), .resp_inst_o(resp_inst_o),
    .resp_err_o(resp_err_o), .resp_ready_i(resp_ready_i), .wr_en_i(wr_en_i),
    .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit bad(input logic [31:0] a);
    return a[1:0] != 2'b00 || a[31:12] != 20'h0;
  endfunction

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 9);
    logic [31:0] w = 32'($urandom_range(0, 15)) << 2;
    if (r == 0) return w + 32'($urandom_range(1, 3));
    if (r == 1) return w | (32'($urandom_range(1, 1000)) << 12);
    return w;
  endfunction

  task automatic step(input bit we, input logic [31:0] wa, input logic [31:0] wd,
                      input bit rv, input logic [31:0] ra, input bit rr);
    bit ev, pp, er, ac;
    ent_t e;
    @(negedge clk);
    wr_en_i = we; wr_addr_i = wa; wr_data_i = wd;
    req_valid_i = rv; req_addr_i = ra; resp_ready_i = rr;
    #1;
    ev = q.size() > 0 && q[0].vis <= cyc;
    pp = ev && rr;
    er = !we && (q.size() - int'(pp)) < 2;
    chk("req_ready", 32'(req_ready_o), 32'(er));
    chk("resp_valid", 32'(resp_valid_o), 32'(ev));
    if (ev) begin
      chk("resp_inst", resp_inst_o, q[0].inst);
      chk("resp_err", 32'(resp_err_o), 32'(q[0].err));
    end
    ac = rv && er;
    e.err = bad(ra);
    e.inst = e.err ? 32'h0 : mdl[ra[11:2]];
    @(posedge clk);
    cyc++;
    if (pp) void'(q.pop_front());
    if (we && !bad(wa)) mdl[wa[11:2]] = wd;
    if (ac) begin
      e.vis = cyc + 1;
      q.push_back(e);
    end
  endtask

  task automatic idle(input bit rr);
    step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, rr);
  endtask

  task automatic fetch(input logic [31:0] a, input bit rr);
    step(1'b0, 32'h0, 32'h0, 1'b1, a, rr);
  endtask

  initial begin
    #1;
    chk("rst_valid", 32'(resp_valid_o), 32'h0);
    chk("rst_err", 32'(resp_err_o), 32'h0);
    chk("rst_inst", resp_inst_o, 32'h0);
    chk("rst_ready", 32'(req_ready_o), 32'h0);
    #20;
    @(negedge clk) rstn = 1'b1;
    #1 chk("rel_ready", 32'(req_ready_o), 32'h1);
    for (int i = 0; i < 16; i++) step(1'b1, 32'(i * 4), $urandom, 1'b0, 32'h0, 1'b1);
    // load then back-to-back fetch
    step(1'b1, 32'h0, 32'h3401_1100, 1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h4, 32'h3402_0020, 1'b0, 32'h0, 1'b1);
    fetch(32'h0, 1'b1);
    fetch(32'h4, 1'b1);
    idle(1'b1);
    idle(1'b1);
    // backpressure: third request stalls, then drains in order
    fetch(32'h0, 1'b0);
    fetch(32'h4, 1'b0);
    fetch(32'h8, 1'b0);
    chk("bp_head", resp_inst_o, 32'h3401_1100);
    fetch(32'h8, 1'b1);
    repeat (3) idle(1'b1);
    // error responses
    fetch(32'h2, 1'b1);
    fetch(32'h1000, 1'b1);
    fetch(32'h0, 1'b1);
    repeat (3) idle(1'b1);
    // write collides with a fetch of the same word
    step(1'b1, 32'h8, 32'hDEAD_BEEF, 1'b1, 32'h8, 1'b1);
    fetch(32'h8, 1'b1);
    idle(1'b1);
    idle(1'b1);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 4) == 0, rand_addr(), $urandom,
           $urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 3) != 0);
    repeat (3) idle(1'b1);
    // reset with two responses buffered
    fetch(32'h0, 1'b0);
    fetch(32'h4, 1'b0);
    idle(1'b0);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(resp_valid_o), 32'h0);
    chk("mid_rst_inst", resp_inst_o, 32'h0);
    chk("mid_rst_err", 32'(resp_err_o), 32'h0);
    chk("mid_rst_ready", 32'(req_ready_o), 32'h0);
    q.delete();
    req_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    #1 chk("rel2_ready", 32'(req_ready_o), 32'h1);
    fetch(32'h0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
